// File: rtl/cas_sort_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cas_pkg
//  Brief    : Shared types and compare-and-swap schedule for cas_sort_sched.
//  Revision : 1.0  initial release
// ============================================================================
package cas_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int CAS_STEPS = 5;

  // Comparator network for 4 entries, element [k] is step k:
  //   step : 0 1 2 3 4
  //   hi   : 0 2 0 1 1
  //   lo   : 1 3 2 3 2
  localparam logic [CAS_STEPS-1:0][1:0] PAIR_HI = {2'd1, 2'd1, 2'd0, 2'd2, 2'd0};
  localparam logic [CAS_STEPS-1:0][1:0] PAIR_LO = {2'd2, 2'd3, 2'd2, 2'd3, 2'd1};

endpackage
`default_nettype wire

// File: rtl/cas_sort_sched_cas.sv
`default_nettype none
// ============================================================================
//  Module   : cas
//  Brief    : Unsigned compare-and-swap; hi gets the max, lo the min.
//             Equal operands keep their original order.
//  Revision : 1.0  initial release
// ============================================================================
module cas #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             swap
);

  logic [WIDTH:0] w_diff;

  // Zero-extended subtract: the borrow bit is set exactly when a < b.
  assign w_diff = {1'b0, a} - {1'b0, b};
  assign swap   = w_diff[WIDTH];
  assign hi     = swap ? b : a;
  // a - (a - b) recovers b modulo 2^WIDTH, so the low diff bits double as the
  // path for b when no swap happens.
  assign lo     = swap ? a : (a - w_diff[WIDTH-1:0]);

endmodule
`default_nettype wire

// File: rtl/cas_sort_sched.sv
`default_nettype none
// ============================================================================
//  Module   : cas_sort_sched
//  Brief    : 4-entry sorter sharing one compare-and-swap unit over a 5-step
//             schedule. Loads 4 words, sorts in place, drains largest first.
//  Options  : CAS_SORT_SWAPCNT_EN adds the swap_cnt output (swaps per sort).
//  Revision : 1.0  initial release
// ============================================================================
module cas_sort_sched
  import cas_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_ITEMS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
`ifdef CAS_SORT_SWAPCNT_EN
  ,
  output logic [2:0]       swap_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_ITEMS);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_ITEMS - 1);
  localparam logic [2:0]       C_LAST_STEP = 3'(CAS_STEPS - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_file [NUM_ITEMS];
  logic [IDX_W-1:0] r_wr_idx;
  logic [IDX_W-1:0] r_rd_idx;
  logic [2:0]       r_step;

  logic [IDX_W-1:0] w_hi_idx;
  logic [IDX_W-1:0] w_lo_idx;
  logic [WIDTH-1:0] w_cas_hi;
  logic [WIDTH-1:0] w_cas_lo;
  logic             w_swap;
  logic             w_load_done;

  assign w_hi_idx    = PAIR_HI[r_step];
  assign w_lo_idx    = PAIR_LO[r_step];
  assign w_load_done = (r_state == LOAD) && in_valid && in_ready && (r_wr_idx == C_LAST_IDX);
  assign out_data    = r_file[r_rd_idx];

  cas #(.WIDTH(WIDTH)) u_cas (
    .a    (r_file[w_hi_idx]),
    .b    (r_file[w_lo_idx]),
    .hi   (w_cas_hi),
    .lo   (w_cas_lo),
    .swap (w_swap)
  );

  // Load/sort/drain sequencer with registered handshake flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= LOAD;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      r_wr_idx  <= '0;
      r_rd_idx  <= '0;
      r_step    <= '0;
      for (int i = 0; i < NUM_ITEMS; i++) r_file[i] <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (in_valid && in_ready) begin
            r_file[r_wr_idx] <= in_data;
            if (r_wr_idx == C_LAST_IDX) begin
              r_wr_idx <= '0;
              r_step   <= '0;
              r_state  <= SORT;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              r_wr_idx <= r_wr_idx + 1'b1;
            end
          end
        end
        SORT: begin
          r_file[w_hi_idx] <= w_cas_hi;
          r_file[w_lo_idx] <= w_cas_lo;
          if (r_step == C_LAST_STEP) begin
            r_step    <= '0;
            r_rd_idx  <= '0;
            r_state   <= DRAIN;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
          end else begin
            r_step <= r_step + 3'd1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (r_rd_idx == C_LAST_IDX) begin
              r_rd_idx  <= '0;
              r_state   <= LOAD;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
            end else begin
              r_rd_idx <= r_rd_idx + 1'b1;
              out_last <= ((r_rd_idx + 1'b1) == C_LAST_IDX);
            end
          end
        end
        default: begin
          r_state   <= LOAD;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef CAS_SORT_SWAPCNT_EN
  // Count swapping steps of the current sort; held until the next sort starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swap_cnt <= 3'd0;
    end else if (w_load_done) begin
      swap_cnt <= 3'd0;
    end else if ((r_state == SORT) && w_swap) begin
      swap_cnt <= swap_cnt + 3'd1;
    end
  end
`endif

endmodule
`default_nettype wire
